zeroskip_expand_pipe: RTL

- Inverse of the MAC zero-skip encoder. Takes compressed activation groups and their zero/non-zero (ZNZ) masks, and re-inserts zeros to rebuild the dense activation vector.
- Sits on the write-back/debug path after the MAC array, and in the DV scoreboard model. It round-trips encoded data back to dense form.
- Supports two sparsity modes:
  - 8:16 (half): one compressed beat produces one dense beat.
  - 4:16 (quarter): one compressed beat carries two packed vectors and produces two dense beats.

---
 rtl/zeroskip_expand_pipe.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/zeroskip_expand_pipe.sv
// Zero-skip expander: rebuilds dense activation vectors from compressed
// slot groups and their ZNZ masks. Half mode (8:16) yields one dense beat
// per input; quarter mode (4:16) yields vector A, then the held vector B.
module zeroskip_expand_pipe #(
  parameter int NUM_GROUPS   = 4,
  parameter int GROUP_SIZE   = 16,
  parameter int GROUP_NZ_MAX = 8,
  parameter int DATA_W       = 8
) (
  input  logic                                      clk,
  input  logic                                      a_rst_n,
  input  logic                                      enable,
  input  logic                                      group_nz_sel,
  input  logic [NUM_GROUPS*GROUP_NZ_MAX*DATA_W-1:0] cmp_din,
  input  logic [2*NUM_GROUPS*GROUP_SIZE-1:0]        znz_din,
  input  logic                                      din_vld_i,
  output logic                                      din_rdy_o,
  output logic [NUM_GROUPS*GROUP_SIZE*DATA_W-1:0]   dense_dout,
  output logic                                      dense_err_o,
  output logic                                      dense_vld_o,
  input  logic                                      dense_rdy_i
);

  localparam int CMP_W   = NUM_GROUPS*GROUP_NZ_MAX*DATA_W;
  localparam int MASK_W  = NUM_GROUPS*GROUP_SIZE;
  localparam int DENSE_W = MASK_W*DATA_W;
  localparam int K_W     = $clog2(GROUP_SIZE+1);
  localparam int HALF_NZ = GROUP_NZ_MAX/2;
  localparam logic [K_W-1:0] CAP_HALF    = K_W'(GROUP_NZ_MAX);
  localparam logic [K_W-1:0] CAP_QUARTER = K_W'(HALF_NZ);

  typedef enum logic [0:0] {ST_A = 1'b0, ST_B = 1'b1} state_t;

  // Expand one vector: returns {err, dense}. Slot window always starts at
  // slot 0 of each group; the B window is pre-shifted when captured.
  function automatic logic [DENSE_W:0] expand_vec(
    input logic [MASK_W-1:0] mask,
    input logic [CMP_W-1:0]  slots,
    input logic              quarter
  );
    logic [DENSE_W-1:0] dense;
    logic               err;
    logic [K_W-1:0]     k;
    logic [K_W-1:0]     cap;
    dense = '0;
    err   = 1'b0;
    cap   = quarter ? CAP_QUARTER : CAP_HALF;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      k = '0;
      for (int p = 0; p < GROUP_SIZE; p++) begin
        if (mask[g*GROUP_SIZE+p]) begin
          if (k < cap) begin
            dense[(g*GROUP_SIZE+p)*DATA_W +: DATA_W] =
              slots[(g*GROUP_NZ_MAX + 32'(k))*DATA_W +: DATA_W];
          end else begin
            err = 1'b1;
          end
          k = k + K_W'(1);
        end else begin
          k = k;
        end
      end
    end
    return {err, dense};
  endfunction

  // Move the upper half-window (B slots) of every group down to slot 0.
  function automatic logic [CMP_W-1:0] b_window(input logic [CMP_W-1:0] slots);
    logic [CMP_W-1:0] w;
    w = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      for (int k = 0; k < HALF_NZ; k++) begin
        w[(g*GROUP_NZ_MAX+k)*DATA_W +: DATA_W] =
          slots[(g*GROUP_NZ_MAX+HALF_NZ+k)*DATA_W +: DATA_W];
      end
    end
    return w;
  endfunction

  state_t             state_r, state_nxt_s;
  logic [DENSE_W-1:0] dense_r;
  logic               err_r;
  logic               vld_r;
  logic [CMP_W-1:0]   hold_cmp_r;
  logic [MASK_W-1:0]  hold_mask_r;
  logic               mode_r;

  logic               free_s;
  logic               rdy_s;
  logic               accept_s;
  logic               load_a_s;
  logic               load_b_s;
  logic               capture_s;
  logic               consume_s;
  logic [DENSE_W:0]   exp_a_s;
  logic [DENSE_W:0]   exp_b_s;

  assign exp_a_s = expand_vec(znz_din[MASK_W-1:0], cmp_din, group_nz_sel);
  assign exp_b_s = expand_vec(hold_mask_r, hold_cmp_r, mode_r);

  assign din_rdy_o   = rdy_s;
  assign dense_dout  = dense_r;
  assign dense_err_o = err_r;
  assign dense_vld_o = vld_r;

  // Handshake decode and next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    load_a_s    = 1'b0;
    load_b_s    = 1'b0;
    capture_s   = 1'b0;
    free_s      = !vld_r || dense_rdy_i;
    rdy_s       = enable && (state_r == ST_A) && free_s;
    accept_s    = din_vld_i && rdy_s;
    consume_s   = enable && vld_r && dense_rdy_i;
    case (state_r)
      ST_A: begin
        if (accept_s) begin
          load_a_s = 1'b1;
          if (group_nz_sel) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_B;
          end else begin
            state_nxt_s = ST_A;
          end
        end else begin
          state_nxt_s = ST_A;
        end
      end
      ST_B: begin
        if (enable && free_s) begin
          load_b_s    = 1'b1;
          state_nxt_s = ST_A;
        end else begin
          state_nxt_s = ST_B;
        end
      end
      default: state_nxt_s = ST_A;
    endcase
  end

  // FSM state register; frozen while enable is low.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_r <= ST_A;
    end else if (enable) begin
      state_r <= state_nxt_s;
    end
  end

  // Hold register for the pending B vector and its latched mode.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      hold_cmp_r  <= '0;
      hold_mask_r <= '0;
      mode_r      <= 1'b0;
    end else if (enable && capture_s) begin
      hold_cmp_r  <= b_window(cmp_din);
      hold_mask_r <= znz_din[2*MASK_W-1:MASK_W];
      mode_r      <= group_nz_sel;
    end
  end

  // Output stage: load A or B, or drop valid on a consume without load.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      dense_r <= '0;
      err_r   <= 1'b0;
      vld_r   <= 1'b0;
    end else if (enable) begin
      if (load_a_s) begin
        {err_r, dense_r} <= exp_a_s;
        vld_r            <= 1'b1;
      end else if (load_b_s) begin
        {err_r, dense_r} <= exp_b_s;
        vld_r            <= 1'b1;
      end else if (consume_s) begin
        vld_r <= 1'b0;
      end
    end
  end

endmodule
